// File: rtl/packet_mux.sv
// packet_mux: packet-level round-robin merge of N_CH valid/ready streams onto one tagged output.
// Revision 1.0
`default_nettype none

module packet_mux #(
   parameter int WIDTH = 16,
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH-1:0]       in_last,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   state_t           state;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] pick;
   logic [SEL_W-1:0] cand;
   logic             found;
   logic             space;
   logic             xfer;
   logic             beat_last;
   logic [WIDTH-1:0] beat_data;
   logic [WIDTH-1:0] ch_data [N_CH];

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   endgenerate

   // Search starts one past the last packet's channel so every source gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = last_grant;
      cand  = '0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = SEL_W'((int'(last_grant) + k) % N_CH);
         if (!found && in_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign space     = !out_valid || out_ready;
   assign xfer      = (state == LOCKED) && space && in_valid[grant];
   assign beat_data = ch_data[grant];
   assign beat_last = in_last[grant];

   always_comb begin
      in_ready = '0;
      if (state == LOCKED) begin
         in_ready[grant] = space;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= LAST_CH;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sel    <= '0;
         out_last   <= 1'b0;
      end else begin
         // An accepted beat frees the register unless a new beat lands below.
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= pick;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer) begin
                  out_data  <= beat_data;
                  out_last  <= beat_last;
                  out_sel   <= grant;
                  out_valid <= 1'b1;
                  if (beat_last) begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_packet_mux.sv
// tb_packet_mux: vector table, directed corner sequences and a randomized scoreboard run for packet_mux.
// Revision 1.0
`default_nettype none

module tb_packet_mux;

   localparam int WIDTH = 16;
   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_last;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_sel;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;

   int pass_cnt = 0;
   int total_cnt = 0;

   packet_mux #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [63:0] data;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [15:0] exp_od;
      logic [1:0]  exp_os;
      logic        exp_ol;
   } vec_t;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  s;
      logic        l;
   } obeat_t;

   vec_t   vecs[$];
   beat_t  src_q[N_CH][$];
   obeat_t exp_q[$];
   obeat_t got[$];
   int     m_last_grant;
   int     m_grant;
   bit     m_locked;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d,
                               input logic r, input logic [3:0] er, input logic eov,
                               input logic [15:0] eod, input logic [1:0] eos, input logic eol);
      mk.valid = v; mk.last = l; mk.data = d; mk.ordy = r; mk.exp_rdy = er;
      mk.exp_ov = eov; mk.exp_od = eod; mk.exp_os = eos; mk.exp_ol = eol;
   endfunction

   // Round robin from the spec's rule: first valid channel after the previous winner.
   function automatic int rr_pick(input int lg, input logic [3:0] v);
      for (int k = 1; k <= N_CH; k++) begin
         int c = (lg + k) % N_CH;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_cycle(input bit gaps);
      logic [3:0] exp_rdy;
      bit         was_locked;
      obeat_t     e;
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
         if (src_q[c].size() > 0) begin
            in_valid[c] = gaps ? ($urandom_range(3) != 0) : 1'b1;
            in_data[c*16 +: 16] = src_q[c][0].d;
            in_last[c] = src_q[c][0].l;
         end else begin
            in_valid[c] = 1'b0;
            in_data[c*16 +: 16] = 16'($urandom);
            in_last[c] = 1'($urandom);
         end
      end
      out_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;
      #4;
      exp_rdy = '0;
      if (m_locked) exp_rdy[m_grant] = (exp_q.size() == 0) || out_ready;
      check("rand_in_ready", in_ready, exp_rdy);
      check("rand_out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() > 0) begin
         check("rand_beat", {out_data, out_sel, out_last}, exp_q[0]);
         if (out_ready) e = exp_q.pop_front();
      end
      was_locked = m_locked;
      if (m_locked && in_valid[m_grant] && in_ready[m_grant]) begin
         exp_q.push_back({src_q[m_grant][0].d, 2'(m_grant), src_q[m_grant][0].l});
         if (src_q[m_grant][0].l) begin
            m_locked = 1'b0;
            m_last_grant = m_grant;
         end
         void'(src_q[m_grant].pop_front());
      end
      if (!was_locked && (in_valid != 0)) begin
         m_grant = rr_pick(m_last_grant, in_valid);
         m_locked = 1'b1;
      end
   endtask

   initial begin
      int b, gcnt, nb, prev, remaining;
      bit ch3_done;
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #2;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_sel", out_sel, 0);
      check("reset_out_last", out_last, 0);
      check("reset_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single beat on ch2, then a 3-beat packet on ch1 with ch0 waiting.
      vecs.push_back(mk(4'b0100, 4'b0100, 64'h0000_1234_0000_0000, 1, 4'b0000, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0100, 4'b0100, 64'h0000_1234_0000_0000, 1, 4'b0100, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 1, 16'h1234, 2'd2, 1));
      vecs.push_back(mk(4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0010, 4'b0000, 64'h0000_0000_AAAA_0A00, 1, 4'b0000, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0011, 4'b0001, 64'h0000_0000_AAAA_0A00, 1, 4'b0010, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0011, 4'b0001, 64'h0000_0000_BBBB_0A00, 1, 4'b0010, 1, 16'hAAAA, 2'd1, 0));
      vecs.push_back(mk(4'b0011, 4'b0011, 64'h0000_0000_CCCC_0A00, 1, 4'b0010, 1, 16'hBBBB, 2'd1, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, 64'h0000_0000_0000_0A00, 1, 4'b0000, 1, 16'hCCCC, 2'd1, 1));
      vecs.push_back(mk(4'b0001, 4'b0001, 64'h0000_0000_0000_0A00, 1, 4'b0001, 0, 16'h0, 2'd0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 1, 16'h0A00, 2'd0, 1));
      vecs.push_back(mk(4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 16'h0, 2'd0, 0));
      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid = vecs[i].valid; in_last = vecs[i].last;
         in_data = vecs[i].data; out_ready = vecs[i].ordy;
         #4;
         check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
         check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
         if (vecs[i].exp_ov)
            check($sformatf("vec%0d_beat", i), {out_data, out_sel, out_last},
                  {vecs[i].exp_od, vecs[i].exp_os, vecs[i].exp_ol});
      end

      // All channels continuously offering single-beat packets.
      do_reset();
      @(negedge clk);
      in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
      in_data = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
      nb = 0; prev = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         #4;
         if (out_valid) begin
            check("rr_sel", out_sel, nb % 4);
            check("rr_data", out_data, (nb % 4) * 256);
            if (nb > 0) check("rr_spacing", cyc - prev, 2);
            prev = cyc;
            nb++;
         end
         @(negedge clk);
      end
      check("rr_beat_count", nb, 11);

      // Output backpressure for 5 cycles in the middle of a 4-beat packet.
      do_reset();
      @(negedge clk);
      b = 0; got.delete();
      for (int cyc = 0; cyc < 25; cyc++) begin
         in_valid = {3'b000, b < 4};
         in_data[15:0] = 16'hD000 + 16'(b);
         in_last = {3'b000, b == 3};
         out_ready = !(cyc >= 3 && cyc < 8);
         #4;
         if (cyc >= 3 && cyc < 8) begin
            check("bp_hold", {out_valid, out_data, out_sel, out_last}, {1'b1, 16'hD001, 2'd0, 1'b0});
            check("bp_in_ready", in_ready, 0);
         end
         if (out_valid && out_ready) got.push_back({out_data, out_sel, out_last});
         if (in_valid[0] && in_ready[0]) b++;
         @(negedge clk);
      end
      check("bp_count", got.size(), 4);
      foreach (got[k]) check("bp_beat", got[k], {16'hD000 + 16'(k), 2'd0, k == 3});

      // Granted source pauses 3 cycles while ch3 waits.
      do_reset();
      @(negedge clk);
      b = 0; gcnt = 0; ch3_done = 0; got.delete();
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid[0] = (b < 4) && !(b == 2 && gcnt < 3);
         in_valid[3] = !ch3_done;
         in_valid[2:1] = 2'b00;
         in_data[15:0] = 16'hE000 + 16'(b);
         in_data[63:48] = 16'h3333;
         in_last = {1'b1, 2'b00, b == 3};
         out_ready = 1'b1;
         #4;
         if (b == 2 && gcnt < 3) begin
            check("drop_ch3_blocked", in_ready[3], 0);
            if (gcnt >= 1) check("drop_no_beat", out_valid, 0);
            gcnt++;
         end
         if (out_valid && out_ready) got.push_back({out_data, out_sel, out_last});
         if (in_valid[0] && in_ready[0]) b++;
         if (in_valid[3] && in_ready[3]) ch3_done = 1;
         @(negedge clk);
      end
      check("drop_count", got.size(), 5);
      for (int k = 0; k < 4 && k < got.size(); k++)
         check("drop_beat", got[k], {16'hE000 + 16'(k), 2'd0, k == 3});
      if (got.size() == 5) check("drop_ch3_beat", got[4], {16'h3333, 2'd3, 1'b1});

      // Asynchronous reset while a beat sits in the output register.
      do_reset();
      @(negedge clk);
      in_valid = 4'b0010; in_last = 4'b0000; in_data = 64'h0000_0000_5150_0505;
      repeat (2) @(negedge clk);
      in_valid = 4'b0011; in_last = 4'b0001;
      #2;
      check("rst_pre_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      check("rst_release_idle", in_ready, 0);
      @(negedge clk);
      #4;
      check("rst_release_ch0_first", in_ready, 4'b0001);

      // Randomized traffic against the scoreboard.
      for (int c = 0; c < N_CH; c++) begin
         int n = 0;
         for (int p = 0; p < 15; p++) begin
            int len = $urandom_range(4, 1);
            for (int j = 0; j < len; j++) begin
               src_q[c].push_back({16'(c * 16'h1000 + n), j == len - 1});
               n++;
            end
         end
      end
      do_reset();
      m_locked = 0; m_last_grant = N_CH - 1; m_grant = 0; exp_q.delete();
      for (int cyc = 0; cyc < 1500; cyc++) rand_cycle(1'b1);
      for (int cyc = 0; cyc < 600; cyc++) begin
         remaining = exp_q.size();
         for (int c = 0; c < N_CH; c++) remaining += src_q[c].size();
         if (remaining == 0) break;
         rand_cycle(1'b0);
      end
      remaining = exp_q.size();
      for (int c = 0; c < N_CH; c++) remaining += src_q[c].size();
      check("rand_drained", remaining, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
